// File: rtl/shift_sequencer.sv
// Multi-cycle WIDTH-bit shifter built around one 4-bit arithmetic_shifter, one nibble per cycle.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (op_rot selects a rotate instead of a fill shift).

module arithmetic_shifter (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] x,
   output logic [3:0] y
);
   logic [1:0] s;
   logic [2:0] inv;
   logic [3:0] lo_mask;
   logic [3:0] hi_mask;

   // b[2:1] = amount, b[0] = right, b[3] = fill vacated bits with ones; y = bits shifted out
   always_comb begin
      s       = b[2:1];
      inv     = 3'd4 - {1'b0, s};
      lo_mask = 4'b1111 >> inv;
      hi_mask = 4'b1111 << inv;
      if (b[0]) begin
         x = (a >> s) | (b[3] ? hi_mask : 4'b0000);
         y = a << inv;
      end else begin
         x = (a << s) | (b[3] ? lo_mask : 4'b0000);
         y = a >> inv;
      end
   end
endmodule

module shift_sequencer #(
   parameter  int unsigned WIDTH = 16,
   localparam int unsigned AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_data,
   input  logic [AMT_W-1:0] op_amt,
   input  logic             op_dir,
   input  logic             op_fill,
   input  logic             op_rot,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy
);
   localparam int unsigned N     = WIDTH / 4;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [3:0]       carry;
   logic [AMT_W-1:0] remaining;
   logic [IDX_W-1:0] idx;
   logic             dir;
   logic             fill;

   logic [1:0]       s;
   logic [3:0]       lo_mask;
   logic [3:0]       hi_mask;
   logic [IDX_W-1:0] nib_sel;
   logic [3:0]       cur_nib;
   logic [3:0]       sh_b;
   logic [3:0]       sh_x;
   logic [3:0]       sh_y;
   logic [3:0]       fill_carry;
   logic [3:0]       edge_carry;
   logic [3:0]       carry_in;
   logic [3:0]       vac;
   logic [3:0]       new_nib;
   logic [WIDTH-1:0] work_upd;
   logic             last_nib;
   logic             last_pass;

`ifdef SHIFT_SEQ_ROTATE_EN
   logic       rot;
   logic [3:0] far_nib;
   logic [3:0] rot_carry;
`else
   logic       rot_unused;
   assign rot_unused = op_rot;
`endif

   // Pass amount, masks and the nibble being processed this cycle
   always_comb begin
      s       = (remaining >= AMT_W'(3)) ? 2'd3 : remaining[1:0];
      lo_mask = 4'b1111 >> (3'd4 - {1'b0, s});
      hi_mask = 4'b1111 << (3'd4 - {1'b0, s});
      nib_sel = dir ? (IDX_W'(N - 1) - idx) : idx;
      cur_nib = work[{nib_sel, 2'b00} +: 4];
      sh_b    = {1'b0, s, dir};
   end

   arithmetic_shifter u_shifter (
      .a (cur_nib),
      .b (sh_b),
      .x (sh_x),
      .y (sh_y)
   );

   // Merge carry into the shifted nibble; the first nibble of a pass takes the edge carry
   always_comb begin
      fill_carry = fill ? (dir ? hi_mask : lo_mask) : 4'b0000;
`ifdef SHIFT_SEQ_ROTATE_EN
      far_nib    = dir ? work[3:0] : work[WIDTH-1 -: 4];
      rot_carry  = dir ? (far_nib << (3'd4 - {1'b0, s})) : (far_nib >> (3'd4 - {1'b0, s}));
      edge_carry = rot ? rot_carry : fill_carry;
`else
      edge_carry = fill_carry;
`endif
      carry_in  = (idx == '0) ? edge_carry : carry;
      vac       = dir ? hi_mask : lo_mask;
      new_nib   = (sh_x & ~vac) | carry_in;
      work_upd  = work;
      work_upd[{nib_sel, 2'b00} +: 4] = new_nib;
      last_nib  = (idx == IDX_W'(N - 1));
      last_pass = (remaining <= AMT_W'(3));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         start_ready <= 1'b1;
         res_valid   <= 1'b0;
         busy        <= 1'b0;
         res_data    <= '0;
         work        <= '0;
         carry       <= '0;
         remaining   <= '0;
         idx         <= '0;
         dir         <= 1'b0;
         fill        <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
         rot         <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  work        <= op_data;
                  dir         <= op_dir;
                  fill        <= op_fill;
`ifdef SHIFT_SEQ_ROTATE_EN
                  rot         <= op_rot;
`endif
                  remaining   <= op_amt;
                  idx         <= '0;
                  carry       <= '0;
                  start_ready <= 1'b0;
                  busy        <= 1'b1;
                  if (op_amt == '0) begin
                     res_data  <= op_data;
                     res_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state     <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work  <= work_upd;
               carry <= sh_y;
               if (last_nib) begin
                  idx       <= '0;
                  remaining <= remaining - AMT_W'(s);
                  if (last_pass) begin
                     res_data  <= work_upd;
                     res_valid <= 1'b1;
                     state     <= DONE;
                  end
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid   <= 1'b0;
                  busy        <= 1'b0;
                  start_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               start_ready <= 1'b1;
               res_valid   <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed-vector bench for shift_sequencer (WIDTH=16); expected results are hand-computed.

module tb_shift_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic        start_valid;
   logic        start_ready;
   logic [15:0] op_data;
   logic [3:0]  op_amt;
   logic        op_dir;
   logic        op_fill;
   logic        op_rot;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        busy;

   int vectors = 0;
   int errs    = 0;

   always #5 clk = ~clk;

   shift_sequencer #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op_data     (op_data),
      .op_amt      (op_amt),
      .op_dir      (op_dir),
      .op_fill     (op_fill),
      .op_rot      (op_rot),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one op, count edges after the accept edge until res_valid, then handshake
   task automatic do_op(input string tag, input logic [15:0] d, input logic [3:0] amt,
                        input logic dir, input logic fill, input logic rot,
                        input logic [15:0] exp_res, input int exp_cyc, input bit hold);
      int cyc;
      check({tag, " start_ready"}, 32'(start_ready), 32'd1);
      op_data = d; op_amt = amt; op_dir = dir; op_fill = fill; op_rot = rot;
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      op_data = 16'h5A5A; op_amt = 4'd7; op_dir = ~dir; op_fill = ~fill; op_rot = ~rot;
      cyc = 0;
      while (res_valid !== 1'b1 && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
      check({tag, " result"}, 32'(res_data), 32'(exp_res));
      check({tag, " busy in DONE"}, 32'(busy), 32'd1);
      if (hold) begin
         start_valid = 1'b1;
         op_data = 16'h1111; op_amt = 4'd0;
         repeat (3) @(posedge clk);
         #1;
         start_valid = 1'b0;
         check({tag, " hold valid"}, 32'(res_valid), 32'd1);
         check({tag, " hold data"}, 32'(res_data), 32'(exp_res));
         check({tag, " no accept in DONE"}, 32'(start_ready), 32'd0);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check({tag, " valid after hs"}, 32'(res_valid), 32'd0);
      check({tag, " busy after hs"}, 32'(busy), 32'd0);
      check({tag, " data kept in IDLE"}, 32'(res_data), 32'(exp_res));
   endtask

   initial begin
      int seen;
      rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
      op_data = '0; op_amt = '0; op_dir = 1'b0; op_fill = 1'b0; op_rot = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset start_ready", 32'(start_ready), 32'd1);
      check("reset res_valid", 32'(res_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset res_data", 32'(res_data), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // T1: reset while shifting discards the op
      op_data = 16'h1234; op_amt = 4'd9; op_dir = 1'b0; op_fill = 1'b0; op_rot = 1'b0;
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("T1 busy mid shift", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("T1 res_valid", 32'(res_valid), 32'd0);
      check("T1 res_data", 32'(res_data), 32'd0);
      check("T1 start_ready", 32'(start_ready), 32'd1);
      check("T1 busy", 32'(busy), 32'd0);
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (res_valid !== 1'b0) seen++;
      end
      check("T1 no res_valid pulse", 32'(seen), 32'd0);

      do_op("T2", 16'h1234, 4'd4, 1'b0, 1'b0, 1'b0, 16'h2340, 8, 1'b1);
      do_op("T3", 16'h8421, 4'd1, 1'b1, 1'b1, 1'b0, 16'hC210, 4, 1'b0);
      do_op("T4", 16'hBEEF, 4'd0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 0, 1'b1);
      do_op("T5", 16'hF00F, 4'd15, 1'b1, 1'b1, 1'b0, 16'hFFFF, 20, 1'b0);
      do_op("L7", 16'hABCD, 4'd7, 1'b0, 1'b0, 1'b0, 16'hE680, 12, 1'b0);
      do_op("R6", 16'hABCD, 4'd6, 1'b1, 1'b0, 1'b0, 16'h02AF, 8, 1'b0);
      do_op("R2F", 16'h1234, 4'd2, 1'b1, 1'b1, 1'b0, 16'hC48D, 4, 1'b0);
      do_op("L3F", 16'h0000, 4'd3, 1'b0, 1'b1, 1'b0, 16'h0007, 4, 1'b0);
      do_op("L15", 16'h0001, 4'd15, 1'b0, 1'b0, 1'b0, 16'h8000, 20, 1'b0);
`ifdef SHIFT_SEQ_ROTATE_EN
      do_op("T6 rotl", 16'h8001, 4'd1, 1'b0, 1'b0, 1'b1, 16'h0003, 4, 1'b0);
      do_op("rotr", 16'h8001, 4'd1, 1'b1, 1'b0, 1'b1, 16'hC000, 4, 1'b0);
      do_op("rotl5", 16'h1234, 4'd5, 1'b0, 1'b0, 1'b1, 16'h4682, 8, 1'b0);
`else
      do_op("T6 no rot", 16'h8001, 4'd1, 1'b0, 1'b0, 1'b1, 16'h0002, 4, 1'b0);
      do_op("rotr ignored", 16'h8001, 4'd1, 1'b1, 1'b0, 1'b1, 16'h4000, 4, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
